// File: rtl/norm_quant_packer_if.sv
// Stream interface for norm_quant_packer: normalizer-side int32 samples in,
// packed int8 words out on a valid/ready port with status.
interface norm_quant_packer_if #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                    valid_in;
    logic signed [31:0]      data_in;
    logic                    relu_en;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [8*LANES-1:0]      out_data;
    logic [LANES-1:0]        out_keep;
    logic                    overflow;
    logic [CNT_W-1:0]        fifo_count;

    modport master (
        output valid_in, data_in, relu_en, flush, out_ready,
        input  out_valid, out_data, out_keep, overflow, fifo_count
    );

    modport slave (
        input  valid_in, data_in, relu_en, flush, out_ready,
        output out_valid, out_data, out_keep, overflow, fifo_count
    );
endinterface

// File: rtl/norm_quant_packer.sv
// Saturates int32 samples to int8 (optional ReLU), packs LANES bytes per word and
// buffers completed words in a small FIFO so the non-stalling producer sees no backpressure.
module norm_quant_packer #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    norm_quant_packer_if.slave    bus
);
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WORD_W = 8 * LANES;
    localparam int ENT_W  = WORD_W + LANES;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    logic [7:0]          w_sat_byte;
    logic                r_s1_valid;
    logic                r_s1_flush;
    logic [7:0]          r_s1_byte;

    logic [LIDX_W-1:0]   r_lane_idx;
    logic [WORD_W-1:0]   r_word;
    logic [LANES-1:0]    r_keep;
    logic [WORD_W-1:0]   w_word;
    logic [LANES-1:0]    w_keep;
    logic                w_complete;

    logic [ENT_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic                w_pop;
    logic                w_push;

    always_comb begin
        if (bus.relu_en && (bus.data_in < 32'sd0))
            w_sat_byte = '0;
        else if (bus.data_in > 32'sd127)
            w_sat_byte = 8'h7F;
        else if (bus.data_in < -32'sd128)
            w_sat_byte = 8'h80;
        else
            w_sat_byte = bus.data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_flush <= 1'b0;
            r_s1_byte  <= '0;
        end else begin
            r_s1_valid <= bus.valid_in;
            r_s1_flush <= bus.flush;
            r_s1_byte  <= w_sat_byte;
        end
    end

    // A byte landing in the same cycle as a flush is part of the word being closed.
    always_comb begin
        w_word = r_word;
        w_keep = r_keep;
        if (r_s1_valid) begin
            w_word[8*r_lane_idx +: 8] = r_s1_byte;
            w_keep[r_lane_idx]        = 1'b1;
        end
        w_complete = (r_s1_valid && (r_lane_idx == LAST_LANE)) || (r_s1_flush && (|w_keep));
    end

    always_ff @(posedge clk) begin
        if (reset || w_complete) begin
            r_lane_idx <= '0;
            r_word     <= '0;
            r_keep     <= '0;
        end else if (r_s1_valid) begin
            r_lane_idx <= r_lane_idx + 1'b1;
            r_word     <= w_word;
            r_keep     <= w_keep;
        end
    end

    assign w_pop  = (r_count != '0) && bus.out_ready;
    assign w_push = w_complete && ((r_count < DEPTH_C) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {w_keep, w_word};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            if (w_complete && !w_push)
                r_overflow <= 1'b1;
        end
    end

    assign bus.out_valid  = (r_count != '0);
    assign bus.out_data   = (r_count != '0) ? r_mem[r_rd_ptr][WORD_W-1:0] : '0;
    assign bus.out_keep   = (r_count != '0) ? r_mem[r_rd_ptr][ENT_W-1:WORD_W] : '0;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_norm_quant_packer.sv
// Bench for norm_quant_packer: directed scenarios plus randomized traffic checked
// against a queue-based reference of byte packing and FIFO occupancy.
module tb_norm_quant_packer;
    localparam int LANES      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int ENT_W      = 9 * LANES;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    norm_quant_packer_if #(.LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH)) bus ();
    norm_quant_packer #(.LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]       m_bytes [$];
    logic [ENT_W-1:0] m_fifo  [$];
    bit               m_pend;
    logic [ENT_W-1:0] m_pend_entry;
    bit               m_ovf;

    function automatic logic [7:0] sat8(int d, bit relu);
        if (relu && d < 0) return 8'h00;
        if (d > 127) return 8'h7F;
        if (d < -128) return 8'h80;
        return d[7:0];
    endfunction

    // One clock edge: drive inputs, advance, then update the reference.
    task automatic cycle(input bit v, input int d, input bit relu, input bit fl, input bit rdy, input bit rst);
        bit pop;
        logic [ENT_W-1:0] e;
        reset = rst; bus.valid_in = v; bus.data_in = d; bus.relu_en = relu;
        bus.flush = fl; bus.out_ready = rdy;
        @(posedge clk); #1;
        if (rst) begin
            m_bytes.delete(); m_fifo.delete(); m_pend = 0; m_ovf = 0;
        end else begin
            pop = (m_fifo.size() != 0) && rdy;
            if (m_pend && !(m_fifo.size() < FIFO_DEPTH || pop)) m_ovf = 1;
            if (pop) void'(m_fifo.pop_front());
            if (m_pend && (m_fifo.size() < FIFO_DEPTH)) m_fifo.push_back(m_pend_entry);
            m_pend = 0;
            if (v) m_bytes.push_back(sat8(d, relu));
            if (m_bytes.size() == LANES || (fl && m_bytes.size() != 0)) begin
                e = '0;
                foreach (m_bytes[i]) begin
                    e[8*i +: 8] = m_bytes[i];
                    e[8*LANES + i] = 1'b1;
                end
                m_pend_entry = e; m_pend = 1; m_bytes.delete();
            end
        end
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, 0, 0, rdy, 0);
    endtask

    task automatic test_reset;
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
        n_checks++; if (bus.out_keep !== 4'h0) begin n_fail++; $display("FAIL reset_keep: got %h want 0", bus.out_keep); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
        n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_saturate;
        cycle(1, 5, 0, 0, 0, 0);
        cycle(1, -3, 0, 0, 0, 0);
        cycle(1, 300, 0, 0, 0, 0);
        cycle(1, -1000, 0, 0, 0, 0);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_latency_early: got %b want 0", bus.out_valid); end
        idle(0);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_latency: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'h807FFD05) begin n_fail++; $display("FAIL sat_data: got %h want 807ffd05", bus.out_data); end
        n_checks++; if (bus.out_keep !== 4'hF) begin n_fail++; $display("FAIL sat_keep: got %h want f", bus.out_keep); end
        idle(0);
        n_checks++; if (bus.out_data !== 32'h807FFD05) begin n_fail++; $display("FAIL sat_hold: got %h want 807ffd05", bus.out_data); end
        idle(1);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_pop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_relu;
        cycle(1, -7, 1, 0, 0, 0);
        cycle(1, 10, 1, 0, 0, 0);
        cycle(1, 127, 1, 0, 0, 0);
        cycle(1, 128, 1, 0, 0, 0);
        idle(0);
        n_checks++; if (bus.out_data !== 32'h7F7F0A00) begin n_fail++; $display("FAIL relu_data: got %h want 7f7f0a00", bus.out_data); end
        n_checks++; if (bus.out_keep !== 4'hF) begin n_fail++; $display("FAIL relu_keep: got %h want f", bus.out_keep); end
        idle(1);
    endtask

    task automatic test_flush;
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 2, 0, 0, 0, 0);
        cycle(1, 3, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        idle(0);
        n_checks++; if (bus.out_data !== 32'h00030201) begin n_fail++; $display("FAIL flush_data: got %h want 00030201", bus.out_data); end
        n_checks++; if (bus.out_keep !== 4'h7) begin n_fail++; $display("FAIL flush_keep: got %h want 7", bus.out_keep); end
        cycle(0, 0, 0, 1, 0, 0);
        idle(0);
        idle(0);
        n_checks++; if (bus.fifo_count !== 3'd1) begin n_fail++; $display("FAIL flush_empty_noop: got %0d want 1", bus.fifo_count); end
        idle(1);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_overflow;
        logic [31:0] w;
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < LANES; j++) cycle(1, k*4 + j + 1, 0, 0, 0, 0);
        idle(0);
        n_checks++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", bus.fifo_count); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < LANES; j++) w[8*j +: 8] = 8'(k*4 + j + 1);
            n_checks++; if (bus.out_data !== w) begin n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", k, bus.out_data, w); end
            idle(1);
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    endtask

    task automatic test_full_pushpop;
        cycle(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < LANES; j++) cycle(1, 16*k + j, 0, 0, 0, 0);
        idle(1);
        n_checks++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL pp_count: got %0d want 4", bus.fifo_count); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %b want 0", bus.overflow); end
        n_checks++; if (bus.out_data !== 32'h13121110) begin n_fail++; $display("FAIL pp_head: got %h want 13121110", bus.out_data); end
        for (int k = 0; k < 3; k++) idle(1);
        n_checks++; if (bus.out_data !== 32'h43424140) begin n_fail++; $display("FAIL pp_last: got %h want 43424140", bus.out_data); end
        idle(1);
    endtask

    task automatic test_reset_midword;
        cycle(1, 50, 0, 0, 0, 0);
        cycle(1, 51, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", bus.fifo_count); end
        cycle(1, 9, 0, 0, 0, 0);
        cycle(1, 8, 0, 0, 0, 0);
        cycle(1, 7, 0, 0, 0, 0);
        cycle(1, 6, 0, 0, 0, 0);
        idle(0);
        idle(0);
        n_checks++; if (bus.out_data !== 32'h06070809) begin n_fail++; $display("FAIL rst_mid_data: got %h want 06070809", bus.out_data); end
        n_checks++; if (bus.out_keep !== 4'hF) begin n_fail++; $display("FAIL rst_mid_keep: got %h want f", bus.out_keep); end
        n_checks++; if (bus.fifo_count !== 3'd1) begin n_fail++; $display("FAIL rst_mid_single: got %0d want 1", bus.fifo_count); end
        idle(1);
    endtask

    task automatic test_random;
        int ext[6] = '{-129, -128, -1, 0, 127, 128};
        int d;
        logic [ENT_W-1:0] e;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: d = int'($urandom_range(0, 400)) - 200;
                1: d = int'($urandom());
                2: d = ext[$urandom_range(0, 5)];
                default: d = int'($urandom_range(0, 255)) - 128;
            endcase
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, 0);
            e = (m_fifo.size() != 0) ? m_fifo[0] : '0;
            n_checks++; if (bus.out_valid !== (m_fifo.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", n, bus.out_valid, m_fifo.size() != 0); end
            n_checks++; if (bus.out_data !== e[8*LANES-1:0]) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", n, bus.out_data, e[8*LANES-1:0]); end
            n_checks++; if (bus.out_keep !== e[ENT_W-1:8*LANES]) begin n_fail++; $display("FAIL rnd_keep@%0d: got %h want %h", n, bus.out_keep, e[ENT_W-1:8*LANES]); end
            n_checks++; if (int'(bus.fifo_count) != m_fifo.size()) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, bus.fifo_count, m_fifo.size()); end
            n_checks++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b want %b", n, bus.overflow, m_ovf); end
        end
    endtask

    initial begin
        bus.valid_in = 1'b0; bus.data_in = '0; bus.relu_en = 1'b0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_saturate();
        test_relu();
        test_flush();
        test_overflow();
        test_full_pushpop();
        test_reset_midword();
        cycle(0, 0, 0, 0, 0, 1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
